// File: rtl/score.sv
// Match scorekeeper for a two-player light-cycle game: counts round wins,
// flags the match winner and requests a playfield reset after each crash.
//
// state     | meaning
// PLAY      | round in progress, collisions are scored
// ROUND_END | crash scored, waiting for both heads to leave black
// MATCH_END | a player reached 3 wins, everything holds until NEW_MATCH
module score (
  input  logic       Clk,
  input  logic       Reset_Score,
  input  logic       frame_clk,
  input  logic [2:0] Game_State,
  input  logic [7:0] red_color,
  input  logic [7:0] blue_color,
  output logic [1:0] score_red,
  output logic [1:0] score_blue,
  output logic       Red_W,
  output logic       Blue_W,
  output logic       reset_round
);

  localparam logic [2:0] GS_PLAYING   = 3'd1;
  localparam logic [2:0] GS_NEW_MATCH = 3'd4;
  localparam logic [1:0] SCORE_WIN    = 2'd3;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    ROUND_END = 2'd1,
    MATCH_END = 2'd2
  } state_t;

  state_t state;

  // frame_clk only exists to keep the historical port list intact
  logic frame_unused;
  assign frame_unused = frame_clk;

  logic red_hit, blue_hit, playing;
  assign red_hit  = (red_color == 8'h00);
  assign blue_hit = (blue_color == 8'h00);
  assign playing  = (Game_State == GS_PLAYING);

  always_ff @(posedge Clk or posedge Reset_Score) begin
    if (Reset_Score) begin
      state       <= PLAY;
      score_red   <= 2'd0;
      score_blue  <= 2'd0;
      Red_W       <= 1'b0;
      Blue_W      <= 1'b0;
      reset_round <= 1'b0;
    end else if (Game_State == GS_NEW_MATCH) begin
      state       <= PLAY;
      score_red   <= 2'd0;
      score_blue  <= 2'd0;
      Red_W       <= 1'b0;
      Blue_W      <= 1'b0;
      reset_round <= 1'b0;
    end else begin
      case (state)
        PLAY: begin
          if (playing) begin
            if (red_hit && blue_hit) begin
              state       <= ROUND_END;
              reset_round <= 1'b1;
            end else if (red_hit && score_blue != SCORE_WIN) begin
              score_blue <= score_blue + 2'd1;
              if (score_blue == SCORE_WIN - 2'd1) begin
                state  <= MATCH_END;
                Blue_W <= 1'b1;
              end else begin
                state       <= ROUND_END;
                reset_round <= 1'b1;
              end
            end else if (blue_hit && score_red != SCORE_WIN) begin
              score_red <= score_red + 2'd1;
              if (score_red == SCORE_WIN - 2'd1) begin
                state <= MATCH_END;
                Red_W <= 1'b1;
              end else begin
                state       <= ROUND_END;
                reset_round <= 1'b1;
              end
            end
          end
        end
        // leaving ROUND_END is allowed even while paused
        ROUND_END: begin
          if (!red_hit && !blue_hit) begin
            state       <= PLAY;
            reset_round <= 1'b0;
          end
        end
        MATCH_END: begin
          reset_round <= 1'b0;
        end
        default: begin
          state       <= PLAY;
          reset_round <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score.sv
// Directed bench for score: walks a full match, draws, pause, NEW_MATCH
// priority and asynchronous reset, checking against hand-computed values.
module tb_score;

  logic       Clk = 1'b0;
  logic       Reset_Score;
  logic       frame_clk = 1'b0;
  logic [2:0] Game_State;
  logic [7:0] red_color;
  logic [7:0] blue_color;
  logic [1:0] score_red;
  logic [1:0] score_blue;
  logic       Red_W;
  logic       Blue_W;
  logic       reset_round;

  int n_checks = 0;
  int n_errors = 0;

  score dut (
    .Clk         (Clk),
    .Reset_Score (Reset_Score),
    .frame_clk   (frame_clk),
    .Game_State  (Game_State),
    .red_color   (red_color),
    .blue_color  (blue_color),
    .score_red   (score_red),
    .score_blue  (score_blue),
    .Red_W       (Red_W),
    .Blue_W      (Blue_W),
    .reset_round (reset_round)
  );

  always #10 Clk = ~Clk;
  always #1000 frame_clk = ~frame_clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int sr, input int sb,
                           input int rw, input int bw, input int rr);
    check({tag, " score_red"},   int'(score_red),   sr);
    check({tag, " score_blue"},  int'(score_blue),  sb);
    check({tag, " Red_W"},       int'(Red_W),       rw);
    check({tag, " Blue_W"},      int'(Blue_W),      bw);
    check({tag, " reset_round"}, int'(reset_round), rr);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_colors(input logic [7:0] r, input logic [7:0] b);
    red_color  = r;
    blue_color = b;
  endtask

  initial begin
    Reset_Score = 1'b1;
    Game_State  = 3'd1;
    set_colors(8'h01, 8'h01);
    step();
    check_all("reset", 0, 0, 0, 0, 0);
    Reset_Score = 1'b0;
    step();
    check_all("idle play", 0, 0, 0, 0, 0);

    // red crashes for three cycles: exactly one point to blue
    set_colors(8'h00, 8'h01);
    step(); check_all("red crash c1", 0, 1, 0, 0, 1);
    step(); check_all("red crash c2", 0, 1, 0, 0, 1);
    step(); check_all("red crash c3", 0, 1, 0, 0, 1);
    set_colors(8'h01, 8'h01);
    step(); check_all("round exit", 0, 1, 0, 0, 0);

    set_colors(8'h01, 8'h00);
    step(); check_all("blue crash 1", 1, 1, 0, 0, 1);
    set_colors(8'h01, 8'h01);
    step(); check_all("restore 1", 1, 1, 0, 0, 0);
    set_colors(8'h00, 8'h01);
    step(); check_all("red crash 2", 1, 2, 0, 0, 1);
    set_colors(8'h01, 8'h01);
    step(); check_all("restore 2", 1, 2, 0, 0, 0);
    set_colors(8'h01, 8'h00);
    step(); check_all("blue crash 2", 2, 2, 0, 0, 1);
    set_colors(8'h01, 8'h01);
    step(); check_all("restore 3", 2, 2, 0, 0, 0);
    set_colors(8'h01, 8'h00);
    step(); check_all("red wins match", 3, 2, 1, 0, 0);

    // match over: further crashes ignored, no wrap
    set_colors(8'h01, 8'h01);
    step(); check_all("match hold", 3, 2, 1, 0, 0);
    set_colors(8'h01, 8'h00);
    step(); check_all("match blue crash", 3, 2, 1, 0, 0);
    set_colors(8'h00, 8'h01);
    step(); check_all("match red crash", 3, 2, 1, 0, 0);

    Game_State = 3'd4;
    set_colors(8'h01, 8'h01);
    step(); check_all("new match", 0, 0, 0, 0, 0);
    Game_State = 3'd1;
    step(); check_all("new match idle", 0, 0, 0, 0, 0);

    // draw
    set_colors(8'h00, 8'h00);
    step(); check_all("draw c1", 0, 0, 0, 0, 1);
    step(); check_all("draw c2", 0, 0, 0, 0, 1);
    set_colors(8'h01, 8'h00);
    step(); check_all("draw half restore", 0, 0, 0, 0, 1);
    set_colors(8'h01, 8'h01);
    step(); check_all("draw exit", 0, 0, 0, 0, 0);

    // blue wins a match with three red crashes
    for (int i = 1; i <= 2; i++) begin
      set_colors(8'h00, 8'h01);
      step(); check_all("blue run crash", 0, i, 0, 0, 1);
      set_colors(8'h01, 8'h01);
      step(); check_all("blue run restore", 0, i, 0, 0, 0);
    end
    set_colors(8'h00, 8'h01);
    step(); check_all("blue wins match", 0, 3, 0, 1, 0);

    // NEW_MATCH wins over a simultaneous collision
    Game_State = 3'd4;
    set_colors(8'h01, 8'h00);
    step(); check_all("new match priority", 0, 0, 0, 0, 0);

    // paused: no scoring
    Game_State = 3'd2;
    set_colors(8'h00, 8'h01);
    step(); check_all("paused red crash", 0, 0, 0, 0, 0);
    step(); check_all("paused hold", 0, 0, 0, 0, 0);

    // ROUND_END exit while paused
    Game_State = 3'd1;
    set_colors(8'h01, 8'h00);
    step(); check_all("pre-pause crash", 1, 0, 0, 0, 1);
    Game_State = 3'd5;
    step(); check_all("paused round end", 1, 0, 0, 0, 1);
    set_colors(8'h01, 8'h01);
    step(); check_all("paused round exit", 1, 0, 0, 0, 0);

    // asynchronous reset mid-ROUND_END, between edges
    Game_State = 3'd1;
    set_colors(8'h01, 8'h00);
    step(); check_all("crash before reset", 2, 0, 0, 0, 1);
    #4;
    Reset_Score = 1'b1;
    #1;
    check_all("async reset", 0, 0, 0, 0, 0);
    #2;
    Reset_Score = 1'b0;
    set_colors(8'h01, 8'h01);
    step(); check_all("after reset", 0, 0, 0, 0, 0);
    set_colors(8'h01, 8'h00);
    step(); check_all("resume scoring", 1, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/score.md
SCORE -- requirements
Module: score

Interface
REQ-001 Clk  input  1  system clock (50 MHz); all state updates on its rising edge.
REQ-002 Reset_Score  input  1  reset, asynchronous and active-high.
REQ-003 frame_clk  input  1  frame strobe (~60 Hz); functionally unused, kept for port compatibility.
REQ-004 Game_State  input  3  game mode: 3'd1 = PLAYING, 3'd4 = NEW_MATCH; all other codes = paused.
REQ-005 red_color  input  8  color sampled under the red cycle's head; 8'h00 = red collision.
REQ-006 blue_color  input  8  color sampled under the blue cycle's head; 8'h00 = blue collision.
REQ-007 score_red  output  2  red round wins, 0..3.
REQ-008 score_blue  output  2  blue round wins, 0..3.
REQ-009 Red_W  output  1  high while red has won the match (score_red == 3).
REQ-010 Blue_W  output  1  high while blue has won the match (score_blue == 3).
REQ-011 reset_round  output  1  high while a round has ended and the playfield must be reset.

Function
REQ-012 All outputs SHALL be registered, with no combinational path from input to output.
REQ-013 The FSM SHALL have exactly three states: PLAY, ROUND_END and MATCH_END.
REQ-014 In PLAY with Game_State == 1 and red_color == 0, blue_color != 0, the block SHALL increment score_blue on the same edge and enter ROUND_END.
REQ-015 In PLAY with Game_State == 1 and blue_color == 0, red_color != 0, the block SHALL increment score_red on the same edge and enter ROUND_END.
REQ-016 Simultaneous collision (both colors 0) in PLAY with Game_State == 1 SHALL be a draw: no score change, enter ROUND_END.
REQ-017 reset_round SHALL be 1 exactly while the state is ROUND_END, first visible the edge after the collision was sampled.
REQ-018 ROUND_END SHALL return to PLAY on the first edge where red_color != 0 and blue_color != 0; scoring SHALL be suppressed while in ROUND_END, so one crash yields exactly one point regardless of its duration.
REQ-019 An increment that makes a score 3 SHALL enter MATCH_END instead of ROUND_END, with the matching Red_W/Blue_W set on that edge and reset_round staying 0.
REQ-020 In MATCH_END, scores and win flags SHALL hold and no collision SHALL be scored.
REQ-021 Scores SHALL saturate at 3 and never wrap to 0.
REQ-022 Red_W and Blue_W SHALL never both be 1.
REQ-023 Game_State == 4, in any state, SHALL on the next edge clear both scores, Red_W, Blue_W and reset_round and enter PLAY.
REQ-024 Game_State == 4 SHALL take priority over collision scoring on the same edge.
REQ-025 Game_State not in {1, 4} SHALL freeze state and outputs, with no scoring.
REQ-026 A ROUND_END exit (both colors nonzero) SHALL still be allowed while the game is paused.

Reset
REQ-027 Reset_Score = 1 SHALL immediately, without a clock edge, force state to PLAY and set score_red = 0, score_blue = 0, Red_W = 0, Blue_W = 0 and reset_round = 0.
REQ-028 Reset_Score = 1 mid-round or mid-ROUND_END SHALL abandon that round, with no pending point applied.
REQ-029 After deassertion, operation SHALL resume on the next rising Clk edge.

Verification
REQ-030 Reset, Game_State = 1, both colors 1; red_color = 0 for 3 cycles, then 1 -> score_blue = 1, score_red = 0; reset_round high until red_color returns to 1, then low.
REQ-031 Continuing REQ-030: blue_color = 0 pulse, then red_color = 0 pulse, then blue_color = 0 twice, colors restored between pulses -> score_red 1, 2, 3 and score_blue 2; Red_W = 1 at score_red = 3, with no reset_round pulse on the winning crash.
REQ-032 In MATCH_END, blue_color = 0 -> scores unchanged (3/2) and Blue_W = 0; then Game_State = 4 -> next edge all outputs 0 and state PLAY.
REQ-033 Both colors 0 on the same edge -> scores unchanged and reset_round = 1 until both colors return to nonzero.
REQ-034 Game_State = 2 with red_color = 0 -> no score change; Reset_Score pulsed between clock edges -> outputs 0 immediately.
